// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, SPI mode struct and edge-role helper for the SPI target
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } mode_t;
  function automatic logic sample_is_leading(input logic cpha);
    return !cpha;
  endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: STAGES-flop synchroniser on din with rise/fall detection from one extra flop
module spi_pin_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [STAGES:0] sr;
  always_ff @(posedge clk) sr <= rst ? {(STAGES+1){RST_VAL}} : {sr[STAGES-1:0], din};
  assign dout = sr[STAGES-1];
  assign rise = sr[STAGES-1] & ~sr[STAGES];
  assign fall = ~sr[STAGES-1] & sr[STAGES];
endmodule

// File: rtl/spi_target_core.sv
// spi_target_core: oversampled SPI target, any CPOL/CPHA, DATA_W-bit words, one-entry TX staging
module spi_target_core import spi_pkg::*; #(
  parameter int DATA_W = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_err,
  output logic              tx_underrun,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam mode_t MODE = '{cpol: CPOL, cpha: CPHA};
  state_t state, state_nx;
  logic [CW-1:0] bit_cnt;
  logic [DATA_W-1:0] rx_sh, tx_sh, stage, rx_next, tx_adv, tx_ld;
  logic stage_full, skip, pend;
  logic sck_rise, sck_fall, cs_s, mosi_s, unused_sck_lvl;
  logic [1:0] unused_cs_edges, unused_mosi_edges;
  logic lead, trail, smp, shf, in_shift, done, ld, hs, tx_bit;
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck (
    .clk(clk), .rst(rst), .din(sck_i), .dout(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(cs_n_i), .dout(cs_s), .rise(unused_cs_edges[1]), .fall(unused_cs_edges[0]));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(mosi_i), .dout(mosi_s), .rise(unused_mosi_edges[1]), .fall(unused_mosi_edges[0]));
  assign lead = MODE.cpol ? sck_fall : sck_rise;
  assign trail = MODE.cpol ? sck_rise : sck_fall;
  assign smp = sample_is_leading(MODE.cpha) ? lead : trail;
  assign shf = sample_is_leading(MODE.cpha) ? trail : lead;
  assign in_shift = state == SHIFT && !cs_s;
  assign done = in_shift && smp && bit_cnt == CW'(DATA_W - 1);
  assign ld = state == LOAD || done;
  assign hs = tx_valid && tx_ready;
  assign tx_ready = !stage_full;
  assign busy = state != IDLE;
  assign miso_oe = !cs_s;
  assign rx_next = MSB_FIRST ? {rx_sh[DATA_W-2:0], mosi_s} : {mosi_s, rx_sh[DATA_W-1:1]};
  assign tx_adv = MSB_FIRST ? tx_sh << 1 : tx_sh >> 1;
  assign tx_ld = stage_full ? stage : TX_IDLE;
  assign tx_bit = MSB_FIRST ? tx_sh[DATA_W-1] : tx_sh[0];
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (cs_s ? IDLE : LOAD) : (state == LOAD) ? SHIFT : (cs_s ? IDLE : SHIFT);
  end
  // skip: the first shift edge after a (re)load must keep the freshly loaded first bit on MISO.
  // pend: an empty reload only counts as underrun once the next word's first bit is actually sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      rx_sh <= '0;
      tx_sh <= '0;
      stage <= '0;
      stage_full <= 1'b0;
      skip <= 1'b0;
      pend <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      tx_underrun <= 1'b0;
      miso_o <= 1'b1;
    end else begin
      bit_cnt <= ld ? '0 : (in_shift && smp) ? bit_cnt + CW'(1) : bit_cnt;
      rx_sh <= (in_shift && smp) ? rx_next : rx_sh;
      tx_sh <= ld ? tx_ld : (in_shift && shf && !skip) ? tx_adv : tx_sh;
      skip <= (state == LOAD) ? MODE.cpha : done ? 1'b1 : (in_shift && shf) ? 1'b0 : skip;
      pend <= in_shift ? (done ? !stage_full : smp ? 1'b0 : pend) : 1'b0;
      stage <= hs ? tx_data : stage;
      stage_full <= hs ? 1'b1 : ld ? 1'b0 : stage_full;
      rx_data <= done ? rx_next : rx_data;
      rx_valid <= done;
      frame_err <= state == SHIFT && cs_s && bit_cnt != '0;
      tx_underrun <= (state == LOAD && !stage_full) || (in_shift && smp && pend);
      miso_o <= (state == SHIFT) ? tx_bit : 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_target_core.sv
// tb_spi_target_core: directed scoreboard bench for one 8-bit mode-0 target and four 12-bit LSB-first targets
module tb_spi_target_core;
  localparam int HP = 6;
  typedef struct {int idx; logic [31:0] w;} sb_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] sck = 5'b11000;
  logic [4:0] cs_n = '1;
  logic [4:0] mosi = '0;
  wire [4:0] miso, oe, rxv, ferr, und, busy;
  logic [7:0] tx8 = '0;
  logic txv8 = 1'b0;
  wire txr8;
  wire [7:0] rx8;
  logic [11:0] tx12 [4];
  logic [3:0] txv12 = '0;
  wire [3:0] txr12;
  wire [11:0] rx12 [4];
  wire [31:0] rxw [5];
  sb_t sb[$];
  logic [7:0] feed_q[$];
  int n_chk = 0, n_err = 0;
  int rxv_cnt[5], ferr_cnt[5], und_cnt[5];
  initial forever #5 clk = ~clk;
  spi_target_core #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2), .TX_IDLE(8'hFF)) dut (
    .clk(clk), .rst(rst), .sck_i(sck[0]), .cs_n_i(cs_n[0]), .mosi_i(mosi[0]), .miso_o(miso[0]), .miso_oe(oe[0]),
    .rx_data(rx8), .rx_valid(rxv[0]), .tx_data(tx8), .tx_valid(txv8), .tx_ready(txr8),
    .frame_err(ferr[0]), .tx_underrun(und[0]), .busy(busy[0]));
  assign rxw[0] = {24'b0, rx8};
  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_target_core #(.DATA_W(12), .CPOL(1'((g >> 1) & 1)), .CPHA(1'(g & 1)), .MSB_FIRST(1'b0), .SYNC_STAGES(2), .TX_IDLE(12'hFFF)) dut12 (
      .clk(clk), .rst(rst), .sck_i(sck[g+1]), .cs_n_i(cs_n[g+1]), .mosi_i(mosi[g+1]), .miso_o(miso[g+1]), .miso_oe(oe[g+1]),
      .rx_data(rx12[g]), .rx_valid(rxv[g+1]), .tx_data(tx12[g]), .tx_valid(txv12[g]), .tx_ready(txr12[g]),
      .frame_err(ferr[g+1]), .tx_underrun(und[g+1]), .busy(busy[g+1]));
    assign rxw[g+1] = {20'b0, rx12[g]};
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (rxv[i]) begin
        rxv_cnt[i]++;
        chk("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_idx", 32'(i), 32'(e.idx));
          chk("sb_rx", rxw[i], e.w);
        end
      end
      if (ferr[i]) ferr_cnt[i]++;
      if (und[i]) und_cnt[i]++;
    end
  end
  initial begin
    logic prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (txv8 && prev_rdy) txv8 = 1'b0;
      if (!txv8 && feed_q.size() > 0) begin
        tx8 = feed_q.pop_front();
        txv8 = 1'b1;
      end
      prev_rdy = txr8;
    end
  end
  task automatic xfer(input int idx, input int w, input int nb, input bit cpol, input bit cpha, input bit msb,
                      input logic [31:0] mo, output logic [31:0] mi);
    int k;
    mi = '0;
    if (nb == w) sb.push_back('{idx, mo});
    for (int b = 0; b < nb; b++) begin
      k = msb ? w - 1 - b : b;
      if (!cpha) mosi[idx] = mo[k];
      repeat (HP) @(negedge clk);
      if (!cpha) mi[k] = miso[idx];
      sck[idx] = !cpol;
      if (cpha) mosi[idx] = mo[k];
      repeat (HP) @(negedge clk);
      if (cpha) mi[k] = miso[idx];
      sck[idx] = cpol;
    end
  endtask
  task automatic begin_frame(input int idx);
    cs_n[idx] = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic end_frame(input int idx);
    repeat (HP) @(negedge clk);
    cs_n[idx] = 1'b1;
    repeat (10) @(negedge clk);
  endtask
  task automatic stage12(input int g, input logic [11:0] val);
    @(negedge clk);
    chk("m_tx_ready_pre", 32'(txr12[g]), 32'd1);
    tx12[g] = val;
    txv12[g] = 1'b1;
    @(negedge clk);
    txv12[g] = 1'b0;
    chk("m_tx_ready_post", 32'(txr12[g]), 32'd0);
  endtask
  initial begin
    logic [31:0] mi;
    int r0, u0, f0;
    for (int i = 0; i < 4; i++) tx12[i] = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_miso", 32'(miso[0]), 32'd1);
    chk("rst_oe", 32'(oe[0]), 32'd0);
    chk("rst_rx_data", rxw[0], 32'h0);
    chk("rst_rx_valid", 32'(rxv[0]), 32'd0);
    chk("rst_tx_ready", 32'(txr8), 32'd1);
    chk("rst_frame_err", 32'(ferr[0]), 32'd0);
    chk("rst_underrun", 32'(und[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    // mode 0, single word
    r0 = rxv_cnt[0]; u0 = und_cnt[0];
    feed_q.push_back(8'hA9);
    repeat (4) @(negedge clk);
    chk("m0_staged", 32'(txr8), 32'd0);
    begin_frame(0);
    chk("m0_busy", 32'(busy[0]), 32'd1);
    chk("m0_oe", 32'(oe[0]), 32'd1);
    chk("m0_ready_after_load", 32'(txr8), 32'd1);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'h3C, mi);
    end_frame(0);
    chk("m0_miso_word", mi, 32'hA9);
    chk("m0_rx_data", rxw[0], 32'h3C);
    chk("m0_rx_valid_cnt", 32'(rxv_cnt[0] - r0), 32'd1);
    chk("m0_underrun_cnt", 32'(und_cnt[0] - u0), 32'd0);
    chk("m0_idle_busy", 32'(busy[0]), 32'd0);
    chk("m0_idle_miso", 32'(miso[0]), 32'd1);
    // back-to-back words in one frame
    r0 = rxv_cnt[0]; u0 = und_cnt[0];
    feed_q.push_back(8'hA1); feed_q.push_back(8'hB2); feed_q.push_back(8'hC3);
    repeat (4) @(negedge clk);
    begin_frame(0);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'h11, mi);
    chk("b2b_miso0", mi, 32'hA1);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'h22, mi);
    chk("b2b_miso1", mi, 32'hB2);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'h33, mi);
    chk("b2b_miso2", mi, 32'hC3);
    end_frame(0);
    chk("b2b_rx_valid_cnt", 32'(rxv_cnt[0] - r0), 32'd3);
    chk("b2b_underrun_cnt", 32'(und_cnt[0] - u0), 32'd0);
    chk("b2b_rx_data", rxw[0], 32'h33);
    chk("b2b_ready", 32'(txr8), 32'd1);
    // underrun
    r0 = rxv_cnt[0]; u0 = und_cnt[0];
    begin_frame(0);
    chk("ur_pulse_cnt", 32'(und_cnt[0] - u0), 32'd1);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'h5B, mi);
    end_frame(0);
    chk("ur_miso_word", mi, 32'hFF);
    chk("ur_rx_data", rxw[0], 32'h5B);
    chk("ur_rx_valid_cnt", 32'(rxv_cnt[0] - r0), 32'd1);
    // abort after 5 of 8 bits
    r0 = rxv_cnt[0]; f0 = ferr_cnt[0];
    begin_frame(0);
    xfer(0, 8, 5, 1'b0, 1'b0, 1'b1, 32'hE7, mi);
    end_frame(0);
    chk("ab_frame_err_cnt", 32'(ferr_cnt[0] - f0), 32'd1);
    chk("ab_rx_valid_cnt", 32'(rxv_cnt[0] - r0), 32'd0);
    chk("ab_rx_data", rxw[0], 32'h5B);
    chk("ab_busy", 32'(busy[0]), 32'd0);
    // reset mid-frame
    f0 = ferr_cnt[0]; u0 = und_cnt[0]; r0 = rxv_cnt[0];
    feed_q.push_back(8'h77);
    repeat (4) @(negedge clk);
    begin_frame(0);
    xfer(0, 8, 3, 1'b0, 1'b0, 1'b1, 32'h96, mi);
    rst = 1'b1;
    cs_n[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rs_miso", 32'(miso[0]), 32'd1);
    chk("rs_oe", 32'(oe[0]), 32'd0);
    chk("rs_busy", 32'(busy[0]), 32'd0);
    chk("rs_tx_ready", 32'(txr8), 32'd1);
    chk("rs_rx_data", rxw[0], 32'h0);
    chk("rs_rx_valid", 32'(rxv[0]), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rs_frame_err_cnt", 32'(ferr_cnt[0] - f0), 32'd0);
    chk("rs_underrun_cnt", 32'(und_cnt[0] - u0), 32'd0);
    chk("rs_rx_valid_cnt", 32'(rxv_cnt[0] - r0), 32'd0);
    feed_q.push_back(8'h3D);
    repeat (4) @(negedge clk);
    begin_frame(0);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'hE4, mi);
    end_frame(0);
    chk("rs_next_miso", mi, 32'h3D);
    chk("rs_next_rx_data", rxw[0], 32'hE4);
    // all four modes, 12-bit LSB first
    for (int g = 0; g < 4; g++) begin
      r0 = rxv_cnt[g+1]; u0 = und_cnt[g+1];
      stage12(g, 12'hC71);
      begin_frame(g + 1);
      xfer(g + 1, 12, 12, 1'((g >> 1) & 1), 1'(g & 1), 1'b0, 32'h5A3, mi);
      end_frame(g + 1);
      chk($sformatf("mode%0d_miso", g), mi, 32'hC71);
      chk($sformatf("mode%0d_rx_data", g), rxw[g+1], 32'h5A3);
      chk($sformatf("mode%0d_rx_valid_cnt", g), 32'(rxv_cnt[g+1] - r0), 32'd1);
      chk($sformatf("mode%0d_underrun_cnt", g), 32'(und_cnt[g+1] - u0), 32'd0);
    end
    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
